gate_array_pipe: RTL and testbench
==================================

Name: gate_array_pipe

Overview:
Parametrised, registered successor to the 2-input combinational gate. It applies a selectable bitwise logic function across N_IN operands of WIDTH bits each. It offers two modes: per-beat, and multi-beat accumulate, which folds successive beats into one result. Valid/ready handshake on both sides lets it sit between streaming stages in the logic-unit datapaths.

Parameters:
N_IN, 2, number of operands per beat (legal 2..8)
WIDTH, 1, bits per operand and result (legal 1..32)
CNT_W, 8, width of beat counter reported with each result

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
op  input  3  function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS (operand 0), 7 ZERO
acc_en  input  1  1 = accumulate beats until in_last; 0 = every beat is its own result
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_data  input  N_IN*WIDTH  operands; operand i = in_data[i*WIDTH +: WIDTH]
in_last  input  1  final beat of an accumulate packet (ignored when packet is non-accumulate)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  result
out_beats  output  CNT_W  beats folded into out_data, saturating

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_beats=0, accumulator=0, beat counter=0, state=IDLE. in_ready=0 while rst_n is low.
- Handshake: beat accepted on a rising edge when in_valid && in_ready. in_ready = !out_valid || out_ready, regardless of state. Result consumed when out_valid && out_ready.
- out_valid/out_data/out_beats hold stable while out_valid && !out_ready.
- Per-beat reduction: base function B = AND for op 0/3, OR for 1/4, XOR for 2/5. Beat value r = B reduced across all N_IN operands, bitwise.
- Inverting ops (3/4/5): invert only at the final output, after folding. Final output = ~fold, not a fold of inverted values.
- PASS: r = operand 0, folded by AND across beats.
- ZERO: r = 0, output 0.
- State machine:
  - IDLE: first accepted beat latches op and acc_en into a packet context.
    - If acc_en=0, or in_last=1: result = r (inverted if required), out_beats=1, out_valid=1 next cycle; stay IDLE.
    - Otherwise: acc=r, count=1, go to ACCUM.
  - ACCUM: each accepted beat updates acc = B(acc, r) and count = count+1.
    - Count saturates at 2^CNT_W-1.
    - On in_last=1: out_data = final(acc B r), out_beats = count+1 (saturating), out_valid=1, return to IDLE.
  - op and acc_en inputs are ignored in ACCUM; the latched context governs the whole packet.
- Latency: exactly 1 cycle from acceptance of a result-producing beat to out_valid=1. Throughput: 1 result/cycle with out_ready held 1.
- Simultaneous events: a result consumed and a new result-producing beat accepted on the same edge → out_valid stays 1 with new data, no bubble.
- A non-last beat in ACCUM is accepted even while a previous result is stalled only if in_ready=1. The rule is uniform, no exception.
- Reset mid-packet discards the accumulator and any pending result, with no partial output.
- op=7 or unlisted values never produce X; output is 0.

Decomposition:
- Shared package/header: op encoding constants (OP_AND..OP_ZERO), state encoding (ST_IDLE, ST_ACCUM), helper function for base-op selection and inversion flag.
- One sub-module is natural: gate_reduce (combinational N_IN×WIDTH reduction by base function, parametrised on N_IN and WIDTH). Sequential control, accumulator and output register stay in gate_array_pipe.

Test Plan:
- Truth-table sweep, N_IN=2, WIDTH=1, acc_en=0, out_ready=1: all 4 a/b combos × ops 0..5. AND gives 0,0,0,1; NAND gives 1,1,1,0; XOR gives 0,1,1,0; each result one cycle after acceptance, out_beats=1.
- N_IN=4, WIDTH=8, op=XOR, acc_en=0: operands 0x0F, 0xF0, 0xAA, 0x55 → out_data=0x00. Operands 0xFF, 0x00, 0x00, 0x01 → 0xFE.
- Accumulate, N_IN=2, WIDTH=8, op=NAND, 3 beats: (0xFF,0xF0), (0xFF,0x3C), (0x7F,0xFF, last) → out_data=~(0xF0&0x3C&0x7F)=0xCF, out_beats=3. Changing op to OR on beat 2 has no effect.
- Backpressure: out_ready=0 with result pending → in_ready=0, out_data stable for 5 cycles. Raising out_ready with in_valid=1 gives back-to-back results with no bubble.
- Saturation, CNT_W=2: 6-beat AND packet → out_beats=3.
- Reset: assert rst_n=0 mid-packet after 2 beats → all outputs 0 immediately. After release, a single beat op=OR (0x01,0x02) → 0x03, out_beats=1, with no residue from the old packet.

Source files
------------

// File: rtl/gate_array_pipe_pkg.sv
// Shared encodings and helpers for the registered N-input gate array.
package gate_array_pipe_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;
    localparam logic [2:0] OP_ZERO = 3'd7;

    typedef enum logic [2:0] {
        BASE_AND,
        BASE_OR,
        BASE_XOR,
        BASE_PASS,
        BASE_ZERO
    } base_e;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } state_e;

    function automatic base_e base_of(input logic [2:0] op);
        base_e b;
        unique case (op)
            OP_AND, OP_NAND: b = BASE_AND;
            OP_OR, OP_NOR:   b = BASE_OR;
            OP_XOR, OP_XNOR: b = BASE_XOR;
            OP_PASS:         b = BASE_PASS;
            default:         b = BASE_ZERO;
        endcase
        return b;
    endfunction

    function automatic logic inv_of(input logic [2:0] op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    // PASS folds across beats with AND; ZERO collapses everything to 0.
    function automatic logic [31:0] fold_op(
        input base_e       b,
        input logic [31:0] x,
        input logic [31:0] y
    );
        logic [31:0] f;
        unique case (b)
            BASE_AND, BASE_PASS: f = x & y;
            BASE_OR:             f = x | y;
            BASE_XOR:            f = x ^ y;
            default:             f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/gate_array_pipe_reduce.sv
// Combinational bitwise reduction of N_IN operands by a base function.
module gate_reduce
    import gate_array_pipe_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int WIDTH = 1
) (
    input  base_e                   base,
    input  logic [N_IN*WIDTH-1:0]   data,
    output logic [WIDTH-1:0]        r
);

    logic [WIDTH-1:0] r_and;
    logic [WIDTH-1:0] r_or;
    logic [WIDTH-1:0] r_xor;

    always_comb begin
        r_and = '1;
        r_or  = '0;
        r_xor = '0;
        for (int i = 0; i < N_IN; i++) begin
            r_and = r_and & data[i*WIDTH +: WIDTH];
            r_or  = r_or  | data[i*WIDTH +: WIDTH];
            r_xor = r_xor ^ data[i*WIDTH +: WIDTH];
        end
        unique case (base)
            BASE_AND:  r = r_and;
            BASE_OR:   r = r_or;
            BASE_XOR:  r = r_xor;
            BASE_PASS: r = data[WIDTH-1:0];
            default:   r = '0;
        endcase
    end

endmodule

// File: rtl/gate_array_pipe.sv
// Registered N-input gate array with per-beat and accumulate modes
// behind valid/ready handshakes on both sides.
module gate_array_pipe
    import gate_array_pipe_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              op,
    input  logic                    acc_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CNT_W-1:0]        out_beats
);

    state_e           state_q, state_d;
    base_e            base_q, base_d, cur_base;
    logic             inv_q, inv_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0] r, folded, res_d;
    logic [CNT_W-1:0] beats_d;
    logic             produce, valid_d, accept;

    assign in_ready = rst_n && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // The first beat of a packet is reduced with the live op; later
    // beats use the context latched at packet start.
    assign cur_base = (state_q == ST_IDLE) ? base_of(op) : base_q;

    gate_reduce #(
        .N_IN  (N_IN),
        .WIDTH (WIDTH)
    ) u_reduce (
        .base (cur_base),
        .data (in_data),
        .r    (r)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        inv_d   = inv_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = out_data;
        beats_d = out_beats;
        produce = 1'b0;
        folded  = WIDTH'(fold_op(base_q, 32'(acc_q), 32'(r)));
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    base_d = base_of(op);
                    inv_d  = inv_of(op);
                    if (!acc_en || in_last) begin
                        produce = 1'b1;
                        res_d   = inv_of(op) ? ~r : r;
                        beats_d = CNT_W'(1);
                    end else begin
                        acc_d   = r;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_last) begin
                        produce = 1'b1;
                        res_d   = inv_q ? ~folded : folded;
                        beats_d = cnt_inc;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        acc_d = folded;
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (produce) begin
            valid_d = 1'b1;
        end else if (out_valid && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = out_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            base_q    <= BASE_ZERO;
            inv_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            inv_q     <= inv_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_valid <= valid_d;
            if (produce) begin
                out_data  <= res_d;
                out_beats <= beats_d;
            end
        end
    end

endmodule

// File: tb/tb_gate_array_pipe.sv
// Directed bench: two instances (2x8 with 2-bit counter, 4x8) share stimulus.
module tb_gate_array_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        acc_en = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;

    logic        rdy2, ov2, rdy4, ov4;
    logic [7:0]  od2, od4;
    logic [1:0]  ob2;
    logic [7:0]  ob4;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    gate_array_pipe #(.N_IN(2), .WIDTH(8), .CNT_W(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .acc_en    (acc_en),
        .in_valid  (in_valid),
        .in_ready  (rdy2),
        .in_data   (in_data[15:0]),
        .in_last   (in_last),
        .out_valid (ov2),
        .out_ready (out_ready),
        .out_data  (od2),
        .out_beats (ob2)
    );

    gate_array_pipe #(.N_IN(4), .WIDTH(8), .CNT_W(8)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .acc_en    (acc_en),
        .in_valid  (in_valid),
        .in_ready  (rdy4),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (ov4),
        .out_ready (out_ready),
        .out_data  (od4),
        .out_beats (ob4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive a beat and step past the next rising edge; in_valid stays high.
    task automatic beat(input logic [2:0] o, input logic a,
                        input logic l, input logic [31:0] d);
        op       = o;
        acc_en   = a;
        in_last  = l;
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Truth tables indexed by {a,b}: bit k is the result for a=k[1], b=k[0].
    logic [3:0] tt [6];
    logic [3:0] row;
    logic [7:0] a8, b8, e8;

    initial begin
        tt[0] = 4'b1000;
        tt[1] = 4'b1110;
        tt[2] = 4'b0110;
        tt[3] = 4'b0111;
        tt[4] = 4'b0001;
        tt[5] = 4'b1001;

        #12;
        chk("reset_valid", 32'(ov2), 32'd0);
        chk("reset_data", 32'(od2), 32'd0);
        chk("reset_beats", 32'(ob2), 32'd0);
        chk("reset_ready", 32'(rdy2), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(rdy2), 32'd1);

        for (int o = 0; o < 6; o++) begin
            for (int k = 0; k < 4; k++) begin
                a8  = (k >= 2) ? 8'hFF : 8'h00;
                b8  = (k % 2 == 1) ? 8'hFF : 8'h00;
                row = tt[o];
                e8  = row[k] ? 8'hFF : 8'h00;
                beat(3'(o), 1'b0, 1'b0, {16'h0, b8, a8});
                chk($sformatf("tt_op%0d_ab%0d", o, k), 32'(od2), 32'(e8));
                chk($sformatf("tt_valid_op%0d_ab%0d", o, k), 32'(ov2), 32'd1);
                chk($sformatf("tt_beats_op%0d_ab%0d", o, k), 32'(ob2), 32'd1);
            end
        end
        beat(3'd6, 1'b0, 1'b0, 32'h0000_C35A);
        chk("pass", 32'(od2), 32'h5A);
        beat(3'd7, 1'b0, 1'b0, 32'hFFFF_FFFF);
        chk("zero2", 32'(od2), 32'h00);
        chk("zero4", 32'(od4), 32'h00);

        beat(3'd2, 1'b0, 1'b0, 32'h55AA_F00F);
        chk("xor4_a", 32'(od4), 32'h00);
        beat(3'd2, 1'b0, 1'b0, 32'h0100_00FF);
        chk("xor4_b", 32'(od4), 32'hFE);
        chk("xor4_beats", 32'(ob4), 32'd1);
        idle();
        chk("drained", 32'(ov2), 32'd0);

        beat(3'd3, 1'b1, 1'b0, 32'h0000_F0FF);
        chk("nand_acc_b1", 32'(ov2), 32'd0);
        beat(3'd1, 1'b0, 1'b0, 32'h0000_3CFF);
        chk("nand_acc_b2", 32'(ov2), 32'd0);
        beat(3'd1, 1'b0, 1'b1, 32'h0000_FF7F);
        chk("nand_acc_data", 32'(od2), 32'hCF);
        chk("nand_acc_beats", 32'(ob2), 32'd3);
        chk("nand_acc_valid", 32'(ov2), 32'd1);
        idle();

        out_ready = 1'b0;
        beat(3'd1, 1'b0, 1'b0, 32'h0000_0201);
        in_valid = 1'b0;
        chk("bp_data", 32'(od2), 32'h03);
        chk("bp_ready", 32'(rdy2), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold_data%0d", i), 32'(od2), 32'h03);
            chk($sformatf("bp_hold_valid%0d", i), 32'(ov2), 32'd1);
        end
        out_ready = 1'b1;
        beat(3'd2, 1'b0, 1'b0, 32'h0000_F00F);
        chk("b2b_1_valid", 32'(ov2), 32'd1);
        chk("b2b_1_data", 32'(od2), 32'hFF);
        beat(3'd2, 1'b0, 1'b0, 32'h0000_0301);
        chk("b2b_2_valid", 32'(ov2), 32'd1);
        chk("b2b_2_data", 32'(od2), 32'h02);
        idle();

        for (int i = 0; i < 5; i++) begin
            beat(3'd0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        end
        beat(3'd0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("sat_beats2", 32'(ob2), 32'd3);
        chk("sat_data2", 32'(od2), 32'hFF);
        chk("sat_beats4", 32'(ob4), 32'd6);
        idle();

        beat(3'd0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        beat(3'd0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(ov2), 32'd0);
        chk("rst_mid_data", 32'(od2), 32'd0);
        chk("rst_mid_beats", 32'(ob2), 32'd0);
        chk("rst_mid_ready", 32'(rdy2), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat(3'd1, 1'b0, 1'b0, 32'h0000_0201);
        chk("post_rst_data", 32'(od2), 32'h03);
        chk("post_rst_beats", 32'(ob2), 32'd1);
        chk("post_rst_valid", 32'(ov2), 32'd1);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
